// File: rtl/uart_pkg.sv
// Shared register offsets, status bit positions and serial FSM state types for apb_uart_fifo.
package uart_pkg;

    localparam int DIV_W = 16;

    localparam logic [2:0] OFF_DATA = 3'd0;
    localparam logic [2:0] OFF_IER  = 3'd1;
    localparam logic [2:0] OFF_DIVL = 3'd3;
    localparam logic [2:0] OFF_DIVH = 3'd4;
    localparam logic [2:0] OFF_LSR  = 3'd5;
    localparam logic [2:0] OFF_SCR  = 3'd7;

    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_FE   = 3;
    localparam int LSR_THRE = 5;
    localparam int LSR_TEMT = 6;

    localparam int IER_RDA  = 0;
    localparam int IER_THRE = 1;

    // state | meaning: IDLE line idle, START start bit, DATA 8 bits LSB first, STOP stop bit
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [DIV_W-1:0] div_eff(input logic [DIV_W-1:0] div);
        return (div == '0) ? DIV_W'(1) : div;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with fall-through read data; one push and one pop per cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // a full FIFO still takes a push when the same cycle pops
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB-attached 8N1 UART with TX/RX FIFOs, programmable baud divisor and level interrupt.
module apb_uart_fifo
    import uart_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int                    FIFO_DEPTH = 16,
    parameter logic [DIV_W-1:0]      DIV_RESET  = 16'd867
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  ready,
    output logic                  perr,
    output logic                  txd,
    input  logic                  rxd,
    output logic                  irq
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             r_ready, r_perr, r_irq, r_oe, r_fe;
    logic [7:0]       r_prdata, r_scr;
    logic [1:0]       r_ier;
    logic [DIV_W-1:0] r_div, r_baud_cnt, r_rx_cnt;
    tx_state_t        r_tx_state, w_tx_next;
    rx_state_t        r_rx_state, w_rx_next;
    logic [7:0]       r_tx_shift, r_rx_shift;
    logic [2:0]       r_tx_bit, r_rx_bit;
    logic             r_rxd_meta, r_rxd_sync, r_rxd_prev;

    logic             w_access, w_hit, w_err, w_lsr_rd, w_div_wr;
    logic             w_wr_ier, w_wr_divl, w_wr_divh, w_wr_scr;
    logic [2:0]       w_off;
    logic [7:0]       w_rd_data, w_lsr, w_wdata;
    logic [DIV_W-1:0] w_div_eff, w_rx_half;
    logic             w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_tick, w_tx_load, w_txd;
    logic             w_rx_pop, w_rx_full, w_rx_empty, w_rx_due, w_rx_fall;
    logic             w_rx_push, w_rx_ovf, w_rx_fe_set;
    logic [7:0]       w_tx_data, w_rx_data;
    logic [CNT_W-1:0] w_tx_count, w_rx_count;
    logic             w_unused;

    assign w_access  = psel & penable & ~r_ready;
    assign w_hit     = (paddr[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]);
    assign w_off     = paddr[2:0];
    assign w_wdata   = pdata[7:0];
    assign w_div_eff = div_eff(r_div);
    // (DIV+1)/2 - 1 written without a 17-bit intermediate; equal for DIV >= 1
    assign w_rx_half = (w_div_eff - DIV_W'(1)) >> 1;
    assign w_div_wr  = w_wr_divl | w_wr_divh;
    assign w_unused  = &{1'b0, pstb, pdata[DATA_WIDTH-1:8], w_tx_count, w_rx_count};

    assign prdata = {{(DATA_WIDTH-8){1'b0}}, r_prdata};
    assign ready  = r_ready;
    assign perr   = r_perr;
    assign irq    = r_irq;
    assign txd    = w_txd;

    always_comb begin
        w_lsr           = '0;
        w_lsr[LSR_DR]   = ~w_rx_empty;
        w_lsr[LSR_OE]   = r_oe;
        w_lsr[LSR_FE]   = r_fe;
        w_lsr[LSR_THRE] = w_tx_empty;
        w_lsr[LSR_TEMT] = w_tx_empty & (r_tx_state == TX_IDLE);
    end

    always_comb begin
        w_rd_data = '0;
        w_err     = 1'b0;
        w_tx_push = 1'b0;
        w_rx_pop  = 1'b0;
        w_lsr_rd  = 1'b0;
        w_wr_ier  = 1'b0;
        w_wr_divl = 1'b0;
        w_wr_divh = 1'b0;
        w_wr_scr  = 1'b0;
        if (w_access) begin
            if (!w_hit) begin
                w_err = 1'b1;
            end else if (pwrite) begin
                case (w_off)
                    OFF_DATA: begin
                        if (w_tx_full) w_err = 1'b1;
                        else           w_tx_push = 1'b1;
                    end
                    OFF_IER:  w_wr_ier  = 1'b1;
                    OFF_DIVL: w_wr_divl = 1'b1;
                    OFF_DIVH: w_wr_divh = 1'b1;
                    OFF_LSR:  w_err     = 1'b1;
                    OFF_SCR:  w_wr_scr  = 1'b1;
                    default:  ;
                endcase
            end else begin
                case (w_off)
                    OFF_DATA: begin
                        if (!w_rx_empty) begin
                            w_rd_data = w_rx_data;
                            w_rx_pop  = 1'b1;
                        end
                    end
                    OFF_IER:  w_rd_data = {6'b0, r_ier};
                    OFF_DIVL: w_rd_data = r_div[7:0];
                    OFF_DIVH: w_rd_data = r_div[15:8];
                    OFF_LSR: begin
                        w_rd_data = w_lsr;
                        w_lsr_rd  = 1'b1;
                    end
                    OFF_SCR:  w_rd_data = r_scr;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ready  <= 1'b0;
            r_perr   <= 1'b0;
            r_prdata <= '0;
            r_ier    <= '0;
            r_div    <= DIV_RESET;
            r_scr    <= '0;
            r_oe     <= 1'b0;
            r_fe     <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ready  <= w_access;
            r_perr   <= w_err;
            r_prdata <= w_rd_data;
            if (w_wr_ier)  r_ier       <= w_wdata[1:0];
            if (w_wr_divl) r_div[7:0]  <= w_wdata;
            if (w_wr_divh) r_div[15:8] <= w_wdata;
            if (w_wr_scr)  r_scr       <= w_wdata;
            if (w_rx_ovf)       r_oe <= 1'b1;
            else if (w_lsr_rd)  r_oe <= 1'b0;
            if (w_rx_fe_set)    r_fe <= 1'b1;
            else if (w_lsr_rd)  r_fe <= 1'b0;
            r_irq <= (r_ier[IER_RDA] & ~w_rx_empty) | (r_ier[IER_THRE] & w_tx_empty);
        end
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk(pclk), .i_rst_n(presetn), .i_push(w_tx_push), .i_data(w_wdata), .i_pop(w_tx_pop),
        .o_data(w_tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk(pclk), .i_rst_n(presetn), .i_push(w_rx_push), .i_data(r_rx_shift), .i_pop(w_rx_pop),
        .o_data(w_rx_data), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
    );

    // TX: baud counter holds reloaded while idle so every state lasts exactly DIV+1 cycles
    assign w_tx_tick = (r_tx_state != TX_IDLE) && (r_baud_cnt == '0);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_tx_state <= TX_IDLE;
        else          r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (!w_tx_empty) w_tx_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_next = w_tx_empty ? TX_IDLE : TX_START;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_tx_load = (w_tx_next == TX_START) && (r_tx_state != TX_START);
        w_tx_pop  = w_tx_load;
        case (r_tx_state)
            TX_START: w_txd = 1'b0;
            TX_DATA:  w_txd = r_tx_shift[0];
            default:  w_txd = 1'b1;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_baud_cnt <= '0;
        end else begin
            if (w_tx_load)                              r_tx_shift <= w_tx_data;
            else if (r_tx_state == TX_DATA && w_tx_tick) r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            if (r_tx_state != TX_DATA) r_tx_bit <= '0;
            else if (w_tx_tick)        r_tx_bit <= r_tx_bit + 3'd1;
            if (r_tx_state == TX_IDLE || w_div_wr || r_baud_cnt == '0) r_baud_cnt <= w_div_eff;
            else                                                     r_baud_cnt <= r_baud_cnt - DIV_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    assign w_rx_fall = r_rxd_prev & ~r_rxd_sync;
    assign w_rx_due  = (r_rx_state != RX_IDLE) && (r_rx_cnt == '0);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_rx_state <= RX_IDLE;
        else          r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (w_rx_due) w_rx_next = r_rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_due && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_due) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_push   = (r_rx_state == RX_STOP) && w_rx_due;
        w_rx_ovf    = w_rx_push & w_rx_full & ~w_rx_pop;
        w_rx_fe_set = w_rx_push & ~r_rxd_sync;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            if (r_rx_state == RX_IDLE) r_rx_cnt <= w_rx_half;
            else if (r_rx_cnt == '0)   r_rx_cnt <= w_div_eff;
            else                       r_rx_cnt <= r_rx_cnt - DIV_W'(1);
            if (r_rx_state != RX_DATA) r_rx_bit <= '0;
            else if (w_rx_due)         r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_state == RX_DATA && w_rx_due) r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
        end
    end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed self-checking bench for apb_uart_fifo: register table plus serial TX/RX sequences.
module tb_apb_uart_fifo;

    localparam logic [31:0] B = 32'h1000_0000;

    logic        pclk, presetn, psel, penable, pwrite, ready, perr, txd, rxd, irq;
    logic [31:0] paddr, pdata, prdata;
    logic [3:0]  pstb;

    int checks = 0;
    int errors = 0;
    int last_lat;
    logic last_drop;

    apb_uart_fifo dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pdata(pdata), .prdata(prdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb), .ready(ready),
        .perr(perr), .txd(txd), .rxd(rxd), .irq(irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        int n;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pdata = wdata;
        @(negedge pclk);
        penable = 1'b1;
        n = 0;
        do begin
            @(posedge pclk); #1; n++;
        end while (!ready && n < 20);
        rdata = prdata;
        err   = perr;
        last_lat = n;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        last_drop = !ready && (prdata == 32'h0) && !perr;
    endtask

    // Compares every cycle of one 8N1 frame on txd against the ideal waveform
    task automatic capture_frame(input int p, input logic [7:0] exp, output int mism);
        int waited;
        logic eb;
        mism = 0;
        waited = 0;
        @(negedge pclk);
        while (txd !== 1'b0 && waited < 4000) begin
            @(negedge pclk);
            waited++;
        end
        if (waited >= 4000) begin
            mism = 999;
        end else begin
            for (int i = 0; i < 10*p; i++) begin
                if (i < p)        eb = 1'b0;
                else if (i < 9*p) eb = exp[(i-p)/p];
                else              eb = 1'b1;
                if (txd !== eb) mism++;
                if (i < 10*p-1) @(negedge pclk);
            end
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop, input int p);
        @(negedge pclk);
        rxd = 1'b0;
        repeat (p) @(negedge pclk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (p) @(negedge pclk);
        end
        rxd = stop;
        repeat (p) @(negedge pclk);
        rxd = 1'b1;
        repeat (2*p) @(negedge pclk);
    endtask

    logic [31:0] rd, rd2;
    logic        er, er2;
    int          m, mtot, err_cnt, highs;
    logic        last_err;

    initial begin
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pdata = 0; pstb = 4'hF;
        rxd = 1'b1; presetn = 1'b0;

        vecs[0]  = '{1'b0, B+5,    32'h0,        32'h60, 1'b0};
        vecs[1]  = '{1'b0, B+3,    32'h0,        32'h63, 1'b0};
        vecs[2]  = '{1'b0, B+4,    32'h0,        32'h03, 1'b0};
        vecs[3]  = '{1'b0, B+1,    32'h0,        32'h00, 1'b0};
        vecs[4]  = '{1'b0, B+7,    32'h0,        32'h00, 1'b0};
        vecs[5]  = '{1'b1, B+7,    32'h123456C3, 32'h00, 1'b0};
        vecs[6]  = '{1'b0, B+7,    32'h0,        32'hC3, 1'b0};
        vecs[7]  = '{1'b0, B+2,    32'h0,        32'h00, 1'b0};
        vecs[8]  = '{1'b0, B+6,    32'h0,        32'h00, 1'b0};
        vecs[9]  = '{1'b1, B+5,    32'hFF,       32'h00, 1'b1};
        vecs[10] = '{1'b0, B+5,    32'h0,        32'h60, 1'b0};
        vecs[11] = '{1'b0, B+32'h10, 32'h0,      32'h00, 1'b1};
        vecs[12] = '{1'b1, B+32'h10, 32'hAA,     32'h00, 1'b1};
        vecs[13] = '{1'b0, B+0,    32'h0,        32'h00, 1'b0};
        vecs[14] = '{1'b1, B+1,    32'hFF,       32'h00, 1'b0};
        vecs[15] = '{1'b0, B+1,    32'h0,        32'h03, 1'b0};
        vecs[16] = '{1'b1, B+1,    32'h00,       32'h00, 1'b0};
        vecs[17] = '{1'b1, B+2,    32'h5A,       32'h00, 1'b0};
        vecs[18] = '{1'b0, B+8,    32'h0,        32'h00, 1'b1};
        vecs[19] = '{1'b0, 32'h5,  32'h0,        32'h00, 1'b1};
        vecs[20] = '{1'b1, B+3,    32'h03,       32'h00, 1'b0};
        vecs[21] = '{1'b1, B+4,    32'h00,       32'h00, 1'b0};
        vecs[22] = '{1'b0, B+3,    32'h0,        32'h03, 1'b0};
        vecs[23] = '{1'b0, B+4,    32'h0,        32'h00, 1'b0};

        repeat (3) @(negedge pclk);
        chk("rst_txd", {31'b0, txd}, 32'h1);
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_perr", {31'b0, perr}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        presetn = 1'b1;
        repeat (2) @(negedge pclk);

        for (int i = 0; i < 24; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_perr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_ready_pulse", i), {31'b0, (last_lat == 1) && last_drop}, 32'h1);
        end

        // single frame at DIV=3, exact 4-cycle bit cells
        apb(1'b1, B+0, 32'h55, rd, er);
        chk("thr55_perr", {31'b0, er}, 32'h0);
        capture_frame(4, 8'h55, m);
        chk("tx55_wave_mism", m, 0);
        repeat (2) @(negedge pclk);
        apb(1'b0, B+5, 0, rd, er);
        chk("tx55_lsr_temt", rd, 32'h60);

        // DIV=0 behaves as DIV=1
        apb(1'b1, B+3, 32'h00, rd, er);
        apb(1'b1, B+0, 32'hC4, rd, er);
        capture_frame(2, 8'hC4, m);
        chk("div0_wave_mism", m, 0);

        // TX overflow: 0xEE in flight, then 17 writes at DIV=15
        apb(1'b1, B+3, 32'h0F, rd, er);
        mtot = 0; err_cnt = 0; last_err = 1'b0;
        fork
            begin
                for (int k = 0; k < 17; k++) begin
                    capture_frame(16, (k == 0) ? 8'hEE : 8'(k), m);
                    mtot += m;
                end
            end
            begin
                apb(1'b1, B+0, 32'hEE, rd2, er2);
                if (er2) err_cnt++;
                for (int k = 1; k <= 17; k++) begin
                    apb(1'b1, B+0, k, rd2, er2);
                    if (k < 17 && er2) err_cnt++;
                    if (k == 17) last_err = er2;
                end
            end
        join
        chk("txovf_early_perr_count", err_cnt, 0);
        chk("txovf_17th_perr", {31'b0, last_err}, 32'h1);
        chk("txovf_wave_mism", mtot, 0);
        repeat (4) @(negedge pclk);
        apb(1'b0, B+5, 0, rd, er);
        chk("txovf_lsr_idle", rd, 32'h60);

        // RX single byte at DIV=3
        apb(1'b1, B+3, 32'h03, rd, er);
        drive_rx(8'hA3, 1'b1, 4);
        apb(1'b0, B+5, 0, rd, er);
        chk("rx_lsr_dr", rd, 32'h61);
        apb(1'b0, B+0, 0, rd, er);
        chk("rx_rbr_a3", rd, 32'hA3);
        apb(1'b0, B+5, 0, rd, er);
        chk("rx_lsr_empty", rd, 32'h60);
        apb(1'b0, B+0, 0, rd, er);
        chk("rx_rbr_empty_data", rd, 32'h0);
        chk("rx_rbr_empty_perr", {31'b0, er}, 32'h0);

        // RX overrun: 17 frames without reads
        for (int k = 0; k < 17; k++) drive_rx(8'(32'h10 + k), 1'b1, 4);
        apb(1'b0, B+5, 0, rd, er);
        chk("rxovf_lsr", rd, 32'h63);
        mtot = 0;
        for (int k = 0; k < 16; k++) begin
            apb(1'b0, B+0, 0, rd, er);
            if (rd !== 32'(32'h10 + k)) mtot++;
        end
        chk("rxovf_bytes_bad", mtot, 0);
        apb(1'b0, B+5, 0, rd, er);
        chk("rxovf_lsr_cleared", rd, 32'h60);

        // framing error: stop bit low
        drive_rx(8'h3C, 1'b0, 4);
        apb(1'b0, B+5, 0, rd, er);
        chk("fe_lsr_set", rd, 32'h69);
        apb(1'b0, B+5, 0, rd, er);
        chk("fe_lsr_cleared", rd, 32'h61);
        apb(1'b0, B+0, 0, rd, er);
        chk("fe_rbr", rd, 32'h3C);

        // RX-data interrupt
        apb(1'b1, B+1, 32'h01, rd, er);
        @(negedge pclk);
        chk("irq_idle_low", {31'b0, irq}, 32'h0);
        drive_rx(8'h5A, 1'b1, 4);
        chk("irq_rx_high", {31'b0, irq}, 32'h1);
        apb(1'b0, B+0, 0, rd, er);
        chk("irq_rbr", rd, 32'h5A);
        @(negedge pclk);
        chk("irq_after_pop", {31'b0, irq}, 32'h0);
        apb(1'b1, B+1, 32'h02, rd, er);
        @(negedge pclk);
        chk("irq_thre", {31'b0, irq}, 32'h1);
        apb(1'b1, B+1, 32'h00, rd, er);

        // reset in the middle of a frame
        apb(1'b1, B+0, 32'h00, rd, er);
        repeat (12) @(negedge pclk);
        chk("midrst_txd_busy", {31'b0, txd}, 32'h0);
        #2 presetn = 1'b0;
        #1;
        chk("midrst_txd_high", {31'b0, txd}, 32'h1);
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        @(negedge pclk);
        presetn = 1'b1;
        apb(1'b0, B+5, 0, rd, er);
        chk("midrst_lsr", rd, 32'h60);
        apb(1'b0, B+3, 0, rd, er);
        chk("midrst_divl", rd, 32'h63);
        highs = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk);
            if (txd === 1'b1) highs++;
        end
        chk("midrst_txd_quiet", highs, 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_uart_fifo.md
Name: apb_uart_fifo

Overview:
- APB-attached UART, successor to the simulation-only console UART.
- Drives real 8N1 serial TX/RX lines through parametrised TX/RX FIFOs with a programmable baud divisor.
- Keeps the existing register map: data at BASE+0x0, line status at BASE+0x5. Adds interrupt enable, divisor, scratch and error reporting.
- Sits on the peripheral bus at BASE_ADDR; the irq output feeds the platform interrupt controller.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width; registers occupy bits [7:0], upper bits read 0.
- BASE_ADDR, 32'h10000000, register block base; must be 8-byte aligned.
- FIFO_DEPTH, 16, entries per FIFO; power of 2, minimum 2.
- DIV_RESET, 16'd867, divisor reset value; baud = f_pclk/(DIV+1).

Ports:
- pclk  in  1  system clock
- presetn  in  1  asynchronous active-low reset
- paddr  in  ADDR_WIDTH  byte address
- pdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data
- psel  in  1  slave select
- penable  in  1  access phase
- pwrite  in  1  1 = write
- pstb  in  4  byte strobes; ignored, register access uses bits [7:0]
- ready  out  1  transfer complete
- perr  out  1  slave error, valid with ready
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, async; double-flopped internally
- irq  out  1  level interrupt

Behaviour:
- Reset, async on presetn low:
  - ready=0, perr=0, prdata=0, txd=1, irq=0.
  - FIFOs empty; IER=0; DIV=DIV_RESET; SCR=0; OE=FE=0; TX and RX FSMs IDLE.
- Address decode: hit when paddr[ADDR_WIDTH-1:3]==BASE_ADDR[ADDR_WIDTH-1:3]; offset=paddr[2:0].
- Register map:
  - 0: RBR (read, pops RX) / THR (write, pushes TX)
  - 1: IER; bit0 RX-data enable, bit1 THR-empty enable
  - 3: DIV[7:0]
  - 4: DIV[15:8]
  - 5: LSR, read-only; bit0 DR=RX not empty, bit1 OE, bit3 FE, bit5 THRE=TX empty, bit6 TEMT=TX empty and TX FSM idle
  - 7: SCR
  - Offsets 2 and 6 read 0.
- APB handshake:
  - Access phase is psel&penable&!ready. Side effects commit on that edge; ready=1 for exactly the following cycle, then 0.
  - prdata is registered in the same edge; valid while ready=1, 0 otherwise.
  - perr=1 alongside ready on: a miss; a write to offset 5; a THR write while TX is full (byte dropped).
- RBR read when RX empty returns 0 with no pop and perr=0. An LSR read clears OE and FE after returning them.
- FIFO: synchronous, one push and one pop per cycle. Simultaneous push and pop on a full FIFO succeeds with count unchanged; a pop on empty is ignored.
- Baud tick: 16-bit counter reloads at DIV and ticks on 0. DIV=0 is treated as 1. A DIV write restarts the counter.
- TX FSM IDLE→START→DATA(8, LSB first)→STOP→IDLE:
  - Each state lasts DIV+1 cycles.
  - Pops TX FIFO on leaving IDLE when not empty.
  - Back-to-back bytes: STOP goes directly to START.
- RX FSM IDLE→START→DATA→STOP:
  - Falling edge on synced rxd enters START; rxd is sampled at (DIV+1)/2 cycles.
  - Still low: continue, sampling every DIV+1 cycles. High: glitch, return to IDLE.
  - At STOP, push the byte. Stop bit 0 sets FE; the byte is still pushed.
  - RX full at push: byte discarded, OE set.
- irq = (IER[0]&DR) | (IER[1]&THRE), registered.
- Reset mid-frame: txd=1 immediately; partial frames are lost.

Decomposition:
- Package uart_pkg holds:
  - register offset constants
  - LSR bit indices
  - IER bit indices
  - TX/RX state enums
  - DIV width constant
- One sub-module, uart_fifo (parametric WIDTH, DEPTH, with full/empty/count), instantiated twice.

Test Plan:
- Reset → LSR read 8'h60, DIV reads 0x63/0x03, txd=1, ready pulses exactly 1 cycle after each access.
- DIV=3, write THR 0x55 → txd: start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 4 cycles; TEMT=1 after stop.
- Write 17 bytes with FIFO_DEPTH=16 while TX busy → 17th write gives perr=1; bytes 1-16 appear on txd in order.
- Drive 0xA3 on rxd at DIV=3 → LSR=0x61, RBR=0xA3, then LSR=0x60; RBR read when empty returns 0 with perr=0.
- Drive 17 RX frames without reads → LSR bit1=1, first 16 bytes read intact; a frame with stop bit 0 sets FE, cleared by the LSR read.
- IER=2'b01 with an RX byte arriving → irq rises after the stop bit and falls after the RBR pop; access to BASE+0x10 → perr=1, prdata=0.
